// File: rtl/jtag_byte_deframer.sv
// USER-DR scan deframer: drops leading bypass bits and reassembles LSB-first bytes with frame pulses.
// Optional frame statistics (frame_bytes, frame_error) are built when DEFRAMER_STATS_EN is defined.
module jtag_byte_deframer #(
    parameter int SKIP_BITS   = 1,
    parameter int COUNT_WIDTH = 21
) (
    input  logic                   tck,
    input  logic                   rst_n,
    input  logic                   test_logic_reset,
    input  logic                   ir_is_user,
    input  logic                   capture_dr,
    input  logic                   shift_dr,
    input  logic                   update_dr,
    input  logic                   tdi,
    output logic                   byte_valid,
    output logic [7:0]             byte_data,
    output logic                   frame_start,
    output logic                   frame_end,
    output logic [COUNT_WIDTH-1:0] frame_bytes,
    output logic                   frame_error
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SKIP  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    localparam int SKIP_W = (SKIP_BITS > 1) ? $clog2(SKIP_BITS) : 1;
    localparam logic [SKIP_W-1:0] SKIP_LAST = (SKIP_BITS > 0) ? SKIP_W'(SKIP_BITS - 1) : '0;
    localparam state_t FIRST_STATE = (SKIP_BITS == 0) ? ST_SHIFT : ST_SKIP;

    state_t            state_r, state_s;
    logic [SKIP_W-1:0] skip_cnt_r, skip_cnt_s;
    logic [2:0]        bit_idx_r, bit_idx_s;
    logic [7:0]        shreg_r, shreg_s;
    logic [7:0]        byte_data_r, byte_data_s;
    logic              byte_valid_r, byte_valid_s;
    logic              frame_start_r, frame_start_s;
    logic              frame_end_r, frame_end_s;
    logic              abort_s, start_s, end_s;

    // Next-state and datapath: abort beats capture beats update beats shift.
    always_comb begin
        state_s       = state_r;
        skip_cnt_s    = skip_cnt_r;
        bit_idx_s     = bit_idx_r;
        shreg_s       = shreg_r;
        byte_data_s   = byte_data_r;
        byte_valid_s  = 1'b0;
        frame_start_s = 1'b0;
        frame_end_s   = 1'b0;
        abort_s       = test_logic_reset | ~ir_is_user;
        start_s       = ~abort_s & capture_dr;
        end_s         = ~abort_s & ~capture_dr & update_dr & (state_r != ST_IDLE);

        if (abort_s) begin
            state_s    = ST_IDLE;
            skip_cnt_s = '0;
            bit_idx_s  = 3'd0;
            shreg_s    = 8'h00;
        end else if (start_s) begin
            state_s       = FIRST_STATE;
            skip_cnt_s    = '0;
            bit_idx_s     = 3'd0;
            shreg_s       = 8'h00;
            frame_start_s = 1'b1;
        end else if (end_s) begin
            state_s     = ST_IDLE;
            skip_cnt_s  = '0;
            bit_idx_s   = 3'd0;
            shreg_s     = 8'h00;
            frame_end_s = 1'b1;
        end else if (shift_dr) begin
            case (state_r)
                ST_SKIP: begin
                    if (skip_cnt_r == SKIP_LAST) begin
                        state_s    = ST_SHIFT;
                        skip_cnt_s = '0;
                    end else begin
                        skip_cnt_s = skip_cnt_r + SKIP_W'(1);
                    end
                end
                ST_SHIFT: begin
                    shreg_s   = {tdi, shreg_r[7:1]};
                    bit_idx_s = bit_idx_r + 3'd1;
                    if (bit_idx_r == 3'd7) begin
                        byte_data_s  = {tdi, shreg_r[7:1]};
                        byte_valid_s = 1'b1;
                    end else begin
                        byte_valid_s = 1'b0;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State, datapath and output pulse registers.
    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            skip_cnt_r    <= '0;
            bit_idx_r     <= 3'd0;
            shreg_r       <= 8'h00;
            byte_data_r   <= 8'h00;
            byte_valid_r  <= 1'b0;
            frame_start_r <= 1'b0;
            frame_end_r   <= 1'b0;
        end else begin
            state_r       <= state_s;
            skip_cnt_r    <= skip_cnt_s;
            bit_idx_r     <= bit_idx_s;
            shreg_r       <= shreg_s;
            byte_data_r   <= byte_data_s;
            byte_valid_r  <= byte_valid_s;
            frame_start_r <= frame_start_s;
            frame_end_r   <= frame_end_s;
        end
    end

    assign byte_valid  = byte_valid_r;
    assign byte_data   = byte_data_r;
    assign frame_start = frame_start_r;
    assign frame_end   = frame_end_r;

`ifdef DEFRAMER_STATS_EN
    logic [COUNT_WIDTH-1:0] frame_bytes_r, frame_bytes_s;
    logic                   frame_error_r, frame_error_s;

    // A restart over a pending partial byte flags the error even though the new frame begins clean.
    always_comb begin
        frame_bytes_s = frame_bytes_r;
        frame_error_s = frame_error_r;
        if (start_s) begin
            frame_bytes_s = {COUNT_WIDTH{1'b0}};
            frame_error_s = (state_r != ST_IDLE) && (bit_idx_r != 3'd0);
        end else if (end_s) begin
            frame_error_s = frame_error_r | (bit_idx_r != 3'd0);
        end else if (byte_valid_s && (frame_bytes_r != {COUNT_WIDTH{1'b1}})) begin
            frame_bytes_s = frame_bytes_r + COUNT_WIDTH'(1);
        end else begin
            frame_bytes_s = frame_bytes_r;
        end
    end

    // Statistics registers.
    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n) begin
            frame_bytes_r <= {COUNT_WIDTH{1'b0}};
            frame_error_r <= 1'b0;
        end else begin
            frame_bytes_r <= frame_bytes_s;
            frame_error_r <= frame_error_s;
        end
    end

    assign frame_bytes = frame_bytes_r;
    assign frame_error = frame_error_r;
`else
    assign frame_bytes = {COUNT_WIDTH{1'b0}};
    assign frame_error = 1'b0;
`endif

endmodule

// File: tb/tb_jtag_byte_deframer.sv
// Self-checking bench for jtag_byte_deframer: vector table, corner-case sequences, random frames vs a bit-list model.
module tb_jtag_byte_deframer;

    localparam int SKIP = 1;
    localparam int CW   = 21;
`ifdef DEFRAMER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          tck = 1'b0;
    logic          rst_n;
    logic          test_logic_reset;
    logic          ir_is_user;
    logic          capture_dr;
    logic          shift_dr;
    logic          update_dr;
    logic          tdi;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          frame_start;
    logic          frame_end;
    logic [CW-1:0] frame_bytes;
    logic          frame_error;

    jtag_byte_deframer #(.SKIP_BITS(SKIP), .COUNT_WIDTH(CW)) dut (
        .tck(tck), .rst_n(rst_n), .test_logic_reset(test_logic_reset),
        .ir_is_user(ir_is_user), .capture_dr(capture_dr), .shift_dr(shift_dr),
        .update_dr(update_dr), .tdi(tdi), .byte_valid(byte_valid),
        .byte_data(byte_data), .frame_start(frame_start), .frame_end(frame_end),
        .frame_bytes(frame_bytes), .frame_error(frame_error)
    );

    always #5 tck = ~tck;

    int         cycle_no = 0;
    logic [7:0] got_q[$];
    int         got_cyc[$];
    int         n_start = 0;
    int         n_end = 0;
    int         end_cyc = 0;
    int         n_cmp = 0;
    int         n_fail = 0;

    always @(posedge tck) cycle_no <= cycle_no + 1;

    always @(negedge tck) begin
        if (byte_valid === 1'b1) begin
            got_q.push_back(byte_data);
            got_cyc.push_back(cycle_no);
        end
        if (frame_start === 1'b1) n_start++;
        if (frame_end === 1'b1) begin
            n_end++;
            end_cyc = cycle_no;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] sfb(input int v);
        return STATS ? 64'(v) : 64'd0;
    endfunction

    function automatic logic [63:0] serr(input logic v);
        return STATS ? {63'd0, v} : 64'd0;
    endfunction

    task automatic step(input logic c, input logic s, input logic u, input logic d);
        capture_dr = c;
        shift_dr   = s;
        update_dr  = u;
        tdi        = d;
        @(posedge tck);
        #1;
    endtask

    task automatic do_frame(input logic user, input logic skip_val, input int nbits,
                            input logic [63:0] payload, input bit gaps);
        ir_is_user = user;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < SKIP; i++) step(1'b0, 1'b1, 1'b0, skip_val);
        for (int i = 0; i < nbits; i++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) step(1'b0, 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b1, 1'b0, payload[i]);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        ir_is_user = 1'b1;
    endtask

    typedef struct {
        string       name;
        logic        user;
        logic        skip_val;
        int          nbits;
        logic [31:0] payload;
        int          exp_n;
        logic [7:0]  exp_b0;
        logic [7:0]  exp_b1;
        int          exp_start;
        int          exp_end;
        int          exp_fb;
        logic        exp_err;
    } vec_t;

    function automatic vec_t mk(input string nm, input logic u, input logic sv, input int nb,
                                input logic [31:0] p, input int en, input logic [7:0] b0,
                                input logic [7:0] b1, input int es, input int ee,
                                input int fb, input logic er);
        vec_t v;
        v.name = nm; v.user = u; v.skip_val = sv; v.nbits = nb; v.payload = p;
        v.exp_n = en; v.exp_b0 = b0; v.exp_b1 = b1; v.exp_start = es; v.exp_end = ee;
        v.exp_fb = fb; v.exp_err = er;
        return v;
    endfunction

    vec_t vt[8];

    initial begin
        int base_b, base_s, base_e;
        int model_fb, nb;
        logic model_err;
        logic [7:0] exp_q[$];
        logic bq[$];
        logic [7:0] v8;
        logic [63:0] pl;
        logic user;
        bit gaps;

        vt[0] = mk("nominal",  1'b1, 1'b0, 16, 32'h0000_0A31, 2, 8'h31, 8'h0A, 1, 1, 2, 1'b0);
        vt[1] = mk("gated",    1'b0, 1'b0,  8, 32'h0000_0041, 0, 8'h00, 8'h00, 0, 0, 2, 1'b0);
        vt[2] = mk("partial",  1'b1, 1'b1, 11, 32'h0000_05A5, 1, 8'hA5, 8'h00, 1, 1, 1, 1'b1);
        vt[3] = mk("readback", 1'b1, 1'b0, 15, 32'h0000_0000, 1, 8'h00, 8'h00, 1, 1, 1, 1'b1);
        vt[4] = mk("gated2",   1'b0, 1'b1,  8, 32'h0000_00FF, 0, 8'h00, 8'h00, 0, 0, 1, 1'b1);
        vt[5] = mk("single",   1'b1, 1'b1,  8, 32'h0000_00FF, 1, 8'hFF, 8'h00, 1, 1, 1, 1'b0);
        vt[6] = mk("skiponly", 1'b1, 1'b1,  0, 32'h0000_0000, 0, 8'h00, 8'h00, 1, 1, 0, 1'b0);
        vt[7] = mk("seven",    1'b1, 1'b0,  7, 32'h0000_007F, 0, 8'h00, 8'h00, 1, 1, 0, 1'b1);

        rst_n = 1'b0; test_logic_reset = 1'b0; ir_is_user = 1'b0;
        capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0; tdi = 1'b0;
        #2;
        check("rst_byte_valid", {63'd0, byte_valid}, 64'd0);
        check("rst_byte_data", {56'd0, byte_data}, 64'd0);
        check("rst_frame_start", {63'd0, frame_start}, 64'd0);
        check("rst_frame_end", {63'd0, frame_end}, 64'd0);
        check("rst_frame_bytes", 64'(frame_bytes), 64'd0);
        check("rst_frame_error", {63'd0, frame_error}, 64'd0);
        @(negedge tck);
        @(negedge tck);
        rst_n = 1'b1;
        ir_is_user = 1'b1;
        @(posedge tck);
        #1;

        // Vector table.
        for (int r = 0; r < 8; r++) begin
            base_b = got_q.size(); base_s = n_start; base_e = n_end;
            do_frame(vt[r].user, vt[r].skip_val, vt[r].nbits, 64'(vt[r].payload), 1'b0);
            check({vt[r].name, "_nbytes"}, 64'(got_q.size() - base_b), 64'(vt[r].exp_n));
            if (vt[r].exp_n > 0 && got_q.size() > base_b)
                check({vt[r].name, "_byte0"}, {56'd0, got_q[base_b]}, {56'd0, vt[r].exp_b0});
            if (vt[r].exp_n > 1 && got_q.size() > base_b + 1) begin
                check({vt[r].name, "_byte1"}, {56'd0, got_q[base_b+1]}, {56'd0, vt[r].exp_b1});
                check({vt[r].name, "_spacing"}, 64'(got_cyc[base_b+1] - got_cyc[base_b]), 64'd8);
                check({vt[r].name, "_end_gap_ge2"}, {63'd0, (end_cyc - got_cyc[base_b+1]) >= 2}, 64'd1);
            end
            check({vt[r].name, "_starts"}, 64'(n_start - base_s), 64'(vt[r].exp_start));
            check({vt[r].name, "_ends"}, 64'(n_end - base_e), 64'(vt[r].exp_end));
            check({vt[r].name, "_frame_bytes"}, 64'(frame_bytes), sfb(vt[r].exp_fb));
            check({vt[r].name, "_frame_error"}, {63'd0, frame_error}, serr(vt[r].exp_err));
        end

        // Abort by Test-Logic-Reset after 4 data bits, then a clean 0x7E frame.
        base_b = got_q.size(); base_s = n_start; base_e = n_end;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
        test_logic_reset = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        test_logic_reset = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("abort_nbytes", 64'(got_q.size() - base_b), 64'd0);
        check("abort_starts", 64'(n_start - base_s), 64'd1);
        check("abort_ends", 64'(n_end - base_e), 64'd0);
        check("abort_frame_bytes", 64'(frame_bytes), sfb(0));
        base_b = got_q.size();
        do_frame(1'b1, 1'b1, 8, 64'h7E, 1'b0);
        check("after_abort_nbytes", 64'(got_q.size() - base_b), 64'd1);
        if (got_q.size() > base_b) check("after_abort_byte", {56'd0, got_q[base_b]}, 64'h7E);
        check("after_abort_frame_bytes", 64'(frame_bytes), sfb(1));

        // Capture while 3 data bits are pending restarts the frame.
        base_b = got_q.size(); base_s = n_start; base_e = n_end;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        pl = 64'h5A;
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, pl[i]);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("restart_nbytes", 64'(got_q.size() - base_b), 64'd1);
        if (got_q.size() > base_b) check("restart_byte", {56'd0, got_q[base_b]}, 64'h5A);
        check("restart_starts", 64'(n_start - base_s), 64'd2);
        check("restart_ends", 64'(n_end - base_e), 64'd1);
        check("restart_frame_bytes", 64'(frame_bytes), sfb(1));
        check("restart_frame_error", {63'd0, frame_error}, serr(1'b1));

        // ir_is_user dropping mid-frame abandons it.
        base_b = got_q.size(); base_s = n_start; base_e = n_end;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
        ir_is_user = 1'b0;
        step(1'b0, 1'b1, 1'b0, 1'b1);
        ir_is_user = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("irdrop_nbytes", 64'(got_q.size() - base_b), 64'd0);
        check("irdrop_ends", 64'(n_end - base_e), 64'd0);
        check("irdrop_frame_error", {63'd0, frame_error}, serr(1'b0));

        // Asynchronous reset in the middle of a frame, then shifts without a capture.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        pl = 64'hC3;
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, pl[i]);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
        check("pre_rst_byte_data", {56'd0, byte_data}, 64'hC3);
        check("pre_rst_frame_bytes", 64'(frame_bytes), sfb(1));
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_byte_data", {56'd0, byte_data}, 64'd0);
        check("arst_frame_bytes", 64'(frame_bytes), 64'd0);
        check("arst_pulses", {61'd0, byte_valid, frame_start, frame_end}, 64'd0);
        check("arst_frame_error", {63'd0, frame_error}, 64'd0);
        #2;
        rst_n = 1'b1;
        @(posedge tck);
        #1;
        base_b = got_q.size(); base_s = n_start; base_e = n_end;
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("post_rst_nbytes", 64'(got_q.size() - base_b), 64'd0);
        check("post_rst_pulses", 64'((n_start - base_s) + (n_end - base_e)), 64'd0);

        // Random frames against a bit-list model.
        model_fb = 0; model_err = 1'b0;
        for (int f = 0; f < 40; f++) begin
            nb   = $urandom_range(0, 40);
            pl   = {$urandom, $urandom};
            user = ($urandom_range(0, 7) != 0);
            gaps = ($urandom_range(0, 1) == 1);
            exp_q.delete();
            bq.delete();
            if (user) begin
                for (int i = 0; i < nb; i++) bq.push_back(pl[i]);
                for (int k = 0; k + 8 <= bq.size(); k += 8) begin
                    v8 = 8'h00;
                    for (int j = 0; j < 8; j++) v8 = v8 | (8'(bq[k+j]) << j);
                    exp_q.push_back(v8);
                end
                model_fb  = nb / 8;
                model_err = (nb % 8) != 0;
            end
            base_b = got_q.size(); base_s = n_start; base_e = n_end;
            do_frame(user, 1'($urandom_range(0, 1)), nb, pl, gaps);
            check($sformatf("rnd%0d_nbytes", f), 64'(got_q.size() - base_b), 64'(exp_q.size()));
            for (int k = 0; k < exp_q.size() && base_b + k < got_q.size(); k++)
                check($sformatf("rnd%0d_byte%0d", f, k), {56'd0, got_q[base_b+k]}, {56'd0, exp_q[k]});
            if (!gaps) begin
                for (int k = 1; k < exp_q.size() && base_b + k < got_cyc.size(); k++)
                    check($sformatf("rnd%0d_spacing%0d", f, k),
                          64'(got_cyc[base_b+k] - got_cyc[base_b+k-1]), 64'd8);
            end
            check($sformatf("rnd%0d_starts", f), 64'(n_start - base_s), user ? 64'd1 : 64'd0);
            check($sformatf("rnd%0d_ends", f), 64'(n_end - base_e), user ? 64'd1 : 64'd0);
            check($sformatf("rnd%0d_frame_bytes", f), 64'(frame_bytes), sfb(model_fb));
            check($sformatf("rnd%0d_frame_error", f), {63'd0, frame_error}, serr(model_err));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
